// File: rtl/cpu_selftest_seq.sv
// cpu_selftest_seq
// Hardware self-test sequencer for a VeriRisc-style CPU. Each test copies a
// program image from a test ROM into CPU memory with the CPU held in reset,
// releases reset, waits for halt under a cycle timeout, and compares the final
// PC against the expected PC stored after the image. The sequencer runs either
// one selected test or all tests back to back.
//
// Ports
//   clk, rst_        clock, synchronous active-low reset
//   start            1-cycle pulse to begin a session (ignored while busy)
//   run_all          sampled with start: run every test instead of test_sel
//   test_sel         single-mode test index, clamped to NUM_TESTS-1
//   abort            synchronous return to idle (priority over start)
//   rom_addr         {test, word}: words 0..MEM_DEPTH-1 image, MEM_DEPTH expected PC
//   rom_data         ROM read data, one cycle after rom_addr
//   mem_wr_en/addr/data  CPU memory write port
//   cpu_rst_         active-low reset to the CPU
//   halt, pc_addr    CPU status inputs
//   busy, done       session status
//   result_valid     1-cycle pulse per completed test, with test_pass/test_timeout
//   cur_test, final_pc, run_cycles  details of the running / last reported test
//   pass_count, fail_count          saturating session tallies
module cpu_selftest_seq #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_TESTS  = 9,
  parameter int MAX_CYCLES = 8000,
  parameter int RST_CYCLES = 5,
  localparam int TW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int CW = $clog2(MAX_CYCLES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     start,
  input  logic                     run_all,
  input  logic [TW-1:0]            test_sel,
  input  logic                     abort,
  output logic [TW+ADDR_WIDTH:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [DATA_WIDTH-1:0]    mem_wr_data,
  output logic                     cpu_rst_,
  input  logic                     halt,
  input  logic [ADDR_WIDTH-1:0]    pc_addr,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     test_pass,
  output logic                     test_timeout,
  output logic [TW-1:0]            cur_test,
  output logic [ADDR_WIDTH-1:0]    final_pc,
  output logic [CW-1:0]            run_cycles,
  output logic [TW:0]              pass_count,
  output logic [TW:0]              fail_count,
  output logic                     done
);

  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW        = ADDR_WIDTH + 1;
  localparam int HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [LW-1:0] LOAD_WORDS = LW'(MEM_DEPTH);
  localparam logic [LW-1:0] LOAD_LAST  = LW'(MEM_DEPTH + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(MAX_CYCLES - 1);
  localparam logic [TW-1:0] LAST_TEST  = TW'(NUM_TESTS - 1);
  localparam logic [TW:0]   COUNT_MAX  = '1;
  localparam logic [LW-1:0] WORD_ZERO  = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_REPORT,
    S_DONE
  } state_t;

  state_t                 state;
  logic                   run_all_q;
  logic [LW-1:0]          load_cnt;
  logic [HW-1:0]          hold_cnt;
  logic [CW-1:0]          run_cnt;
  logic [ADDR_WIDTH-1:0]  expected_pc;
  logic [TW-1:0]          sel_clamped;
  logic [TW-1:0]          start_test;
  logic                   pc_match;

  assign sel_clamped = (test_sel > LAST_TEST) ? LAST_TEST : test_sel;
  assign start_test  = run_all ? '0 : sel_clamped;
  assign pc_match    = (pc_addr == expected_pc);

  // ROM data arrives one cycle after its address, which is exactly the cycle
  // the registered write strobe for that word is high, so data passes straight
  // through; gating keeps the bus quiet outside write cycles.
  assign mem_wr_data = mem_wr_en ? rom_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state        <= S_IDLE;
      run_all_q    <= 1'b0;
      load_cnt     <= '0;
      hold_cnt     <= '0;
      run_cnt      <= '0;
      expected_pc  <= '0;
      rom_addr     <= '0;
      mem_wr_en    <= 1'b0;
      mem_wr_addr  <= '0;
      cpu_rst_     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      test_pass    <= 1'b0;
      test_timeout <= 1'b0;
      cur_test     <= '0;
      final_pc     <= '0;
      run_cycles   <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
      done         <= 1'b0;
    end else if (abort) begin
      // Abort drops everything in flight but keeps the session tallies.
      state        <= S_IDLE;
      cpu_rst_     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_wr_en    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      mem_wr_en    <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          cpu_rst_ <= 1'b0;
          if (start) begin
            state        <= S_LOAD;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass_count   <= '0;
            fail_count   <= '0;
            run_cycles   <= '0;
            test_pass    <= 1'b0;
            test_timeout <= 1'b0;
            final_pc     <= '0;
            run_all_q    <= run_all;
            cur_test     <= start_test;
            rom_addr     <= {start_test, WORD_ZERO};
            load_cnt     <= '0;
          end
        end

        // load_cnt is the LOAD cycle index: the word fetched this cycle is
        // written next cycle, and the word after the image is the expected PC.
        S_LOAD: begin
          if (load_cnt < LOAD_WORDS) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= load_cnt[ADDR_WIDTH-1:0];
            rom_addr    <= {cur_test, load_cnt + 1'b1};
          end
          if (load_cnt == LOAD_LAST) begin
            expected_pc <= rom_data[ADDR_WIDTH-1:0];
            hold_cnt    <= '0;
            state       <= S_HOLD;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= S_RUN;
            cpu_rst_ <= 1'b1;
            run_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        // A halt on the final allowed cycle counts as a normal halt.
        S_RUN: begin
          if (halt || (run_cnt == RUN_LAST)) begin
            state        <= S_REPORT;
            cpu_rst_     <= 1'b0;
            result_valid <= 1'b1;
            final_pc     <= pc_addr;
            run_cycles   <= run_cnt + 1'b1;
            test_timeout <= !halt;
            test_pass    <= halt && pc_match;
            if (halt && pc_match) begin
              if (pass_count != COUNT_MAX) pass_count <= pass_count + 1'b1;
            end else begin
              if (fail_count != COUNT_MAX) fail_count <= fail_count + 1'b1;
            end
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end

        S_REPORT: begin
          if (run_all_q && (cur_test < LAST_TEST)) begin
            cur_test <= cur_test + 1'b1;
            rom_addr <= {cur_test + 1'b1, WORD_ZERO};
            load_cnt <= '0;
            state    <= S_LOAD;
          end else begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_selftest_seq.sv
// tb_cpu_selftest_seq
// Directed bench for cpu_selftest_seq: ROM model holding nine test images, a
// behavioural CPU stub that halts a set number of cycles after its reset
// rises, and a write/result monitor.
module tb_cpu_selftest_seq;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int NT  = 9;
  localparam int MC  = 100;
  localparam int RC  = 5;
  localparam int TW  = 4;
  localparam int CW  = 7;
  localparam int RAW = TW + AW + 1;

  logic            clk = 1'b0;
  logic            rst_;
  logic            start;
  logic            run_all;
  logic [TW-1:0]   test_sel;
  logic            abort;
  logic [RAW-1:0]  rom_addr;
  logic [DW-1:0]   rom_data = '0;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_wr_addr;
  logic [DW-1:0]   mem_wr_data;
  logic            cpu_rst_;
  logic            halt;
  logic [AW-1:0]   pc_addr;
  logic            busy;
  logic            result_valid;
  logic            test_pass;
  logic            test_timeout;
  logic [TW-1:0]   cur_test;
  logic [AW-1:0]   final_pc;
  logic [CW-1:0]   run_cycles;
  logic [TW:0]     pass_count;
  logic [TW:0]     fail_count;
  logic            done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_selftest_seq #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TESTS(NT),
    .MAX_CYCLES(MC), .RST_CYCLES(RC)
  ) dut (
    .clk(clk), .rst_(rst_), .start(start), .run_all(run_all),
    .test_sel(test_sel), .abort(abort), .rom_addr(rom_addr),
    .rom_data(rom_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .cpu_rst_(cpu_rst_), .halt(halt),
    .pc_addr(pc_addr), .busy(busy), .result_valid(result_valid),
    .test_pass(test_pass), .test_timeout(test_timeout), .cur_test(cur_test),
    .final_pc(final_pc), .run_cycles(run_cycles), .pass_count(pass_count),
    .fail_count(fail_count), .done(done)
  );

  // Image word i of test t; test 0 holds image[i] = i.
  function automatic logic [7:0] img_word(input int t, input int i);
    return 8'((i + 16 * t) & 255);
  endfunction

  // ROM model: registered read, data one cycle after address.
  logic [DW-1:0] rom_mem [0:(1<<RAW)-1];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // CPU stub: counts cycles since its reset rose, halts at RUN cycle stub_n-1.
  int             stub_cnt   = 0;
  int             stub_n     = 40;
  logic           stub_never = 1'b0;
  logic           force_halt = 1'b0;
  logic [AW-1:0]  stub_pc    = 5'h17;
  always @(posedge clk) begin
    if (!cpu_rst_) stub_cnt <= 0;
    else           stub_cnt <= stub_cnt + 1;
  end
  assign halt    = force_halt | (cpu_rst_ && !stub_never && (stub_cnt >= stub_n - 1));
  assign pc_addr = stub_pc;

  // Monitor: checks each write against the expected image, logs results.
  int          mon_epoch     = 0;
  int          seen_epoch    = 0;
  int          mon_test_init = 0;
  int          mon_test      = 0;
  int          wr_count      = 0;
  int          wr_bad        = 0;
  int          rv_count      = 0;
  logic [4:0]  wr_next       = '0;
  logic [15:0] rv_pass_mask  = '0;
  int          rv_tests [0:15];

  always @(negedge clk) begin
    if (seen_epoch != mon_epoch) begin
      seen_epoch   = mon_epoch;
      wr_count     = 0;
      wr_bad       = 0;
      rv_count     = 0;
      wr_next      = '0;
      mon_test     = mon_test_init;
      rv_pass_mask = '0;
    end
    if (mem_wr_en === 1'b1) begin
      if (mem_wr_addr !== wr_next || mem_wr_data !== img_word(mon_test, int'(wr_next))
          || cpu_rst_ !== 1'b0)
        wr_bad++;
      wr_count++;
      if (wr_next == 5'd31) mon_test++;
      wr_next = wr_next + 5'd1;
    end
    if (result_valid === 1'b1) begin
      if (rv_count < 16) rv_tests[rv_count] = int'(cur_test);
      if (test_pass === 1'b1) rv_pass_mask[cur_test] = 1'b1;
      rv_count++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start; returns in the middle of the first cycle after acceptance.
  task automatic apply_stimulus(input logic all, input logic [TW-1:0] sel, input int first_test);
    mon_test_init = first_test;
    mon_epoch++;
    tick();
    start    = 1'b1;
    run_all  = all;
    test_sel = sel;
    tick();
    start   = 1'b0;
    run_all = 1'b0;
  endtask

  // idx = cycle index after the start edge at which result_valid is seen.
  task automatic wait_result(input int limit, output int idx);
    idx = 1;
    while (result_valid !== 1'b1 && idx < limit) begin
      tick();
      idx++;
    end
    check_output("result_valid_seen", 32'(result_valid), 1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check_output("done_seen", 32'(done), 1);
  endtask

  task automatic wait_write(input logic [AW-1:0] addr, input int limit);
    int n = 0;
    while (!(mem_wr_en === 1'b1 && mem_wr_addr === addr) && n < limit) begin
      tick();
      n++;
    end
    check_output("write_seen", 32'(mem_wr_en), 1);
  endtask

  task automatic wait_cpu_run(input int limit);
    int n = 0;
    while (cpu_rst_ !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check_output("cpu_run_seen", 32'(cpu_rst_), 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;

    for (int t = 0; t < 16; t++) begin
      for (int w = 0; w < 64; w++) begin
        if (w < 32)       rom_mem[t*64 + w] = img_word(t, w);
        else if (w == 32) rom_mem[t*64 + w] = (t == 3 || t == 7) ? 8'h11 : 8'h17;
        else              rom_mem[t*64 + w] = 8'h00;
      end
    end

    rst_ = 1'b0; start = 1'b0; abort = 1'b0; run_all = 1'b0; test_sel = '0;
    tick(); tick(); tick();

    // Reset state
    check_output("rst_busy",         32'(busy), 0);
    check_output("rst_done",         32'(done), 0);
    check_output("rst_cpu_rst",      32'(cpu_rst_), 0);
    check_output("rst_mem_wr_en",    32'(mem_wr_en), 0);
    check_output("rst_result_valid", 32'(result_valid), 0);
    check_output("rst_rom_addr",     32'(rom_addr), 0);
    check_output("rst_pass_count",   32'(pass_count), 0);
    check_output("rst_fail_count",   32'(fail_count), 0);
    rst_ = 1'b1;
    tick();

    // T1: single test 0, halt after 40 cycles at the expected PC
    stub_n = 40; stub_pc = 5'h17; stub_never = 1'b0;
    apply_stimulus(1'b0, 4'd0, 0);
    check_output("t1_busy",    32'(busy), 1);
    check_output("t1_cpu_rst", 32'(cpu_rst_), 0);
    wait_result(300, lat);
    check_output("t1_latency",    32'(lat), 80);
    check_output("t1_pass",       32'(test_pass), 1);
    check_output("t1_timeout",    32'(test_timeout), 0);
    check_output("t1_run_cycles", 32'(run_cycles), 40);
    check_output("t1_final_pc",   32'(final_pc), 32'h17);
    check_output("t1_cur_test",   32'(cur_test), 0);
    check_output("t1_rpt_cpu_rst", 32'(cpu_rst_), 0);
    tick();
    check_output("t1_done",       32'(done), 1);
    check_output("t1_busy_end",   32'(busy), 0);
    check_output("t1_pass_count", 32'(pass_count), 1);
    check_output("t1_fail_count", 32'(fail_count), 0);
    check_output("t1_rv_low",     32'(result_valid), 0);
    check_output("t1_wr_count",   32'(wr_count), 32);
    check_output("t1_wr_bad",     32'(wr_bad), 0);
    check_output("t1_rv_count",   32'(rv_count), 1);

    // T2: halt at a wrong PC
    stub_pc = 5'h10;
    apply_stimulus(1'b0, 4'd0, 0);
    check_output("t2_run_cycles_cleared", 32'(run_cycles), 0);
    check_output("t2_done_cleared",       32'(done), 0);
    wait_result(300, lat);
    check_output("t2_pass",       32'(test_pass), 0);
    check_output("t2_timeout",    32'(test_timeout), 0);
    check_output("t2_final_pc",   32'(final_pc), 32'h10);
    check_output("t2_run_cycles", 32'(run_cycles), 40);
    tick();
    check_output("t2_pass_count", 32'(pass_count), 0);
    check_output("t2_fail_count", 32'(fail_count), 1);
    check_output("t2_done",       32'(done), 1);

    // T3: CPU never halts; test_sel 15 clamps to test 8
    stub_never = 1'b1; stub_pc = 5'h17;
    apply_stimulus(1'b0, 4'hF, 8);
    check_output("t3_clamp", 32'(cur_test), 8);
    wait_result(400, lat);
    check_output("t3_latency",    32'(lat), 140);
    check_output("t3_timeout",    32'(test_timeout), 1);
    check_output("t3_pass",       32'(test_pass), 0);
    check_output("t3_run_cycles", 32'(run_cycles), 100);
    check_output("t3_final_pc",   32'(final_pc), 32'h17);
    tick();
    check_output("t3_fail_count", 32'(fail_count), 1);
    check_output("t3_pass_count", 32'(pass_count), 0);
    check_output("t3_wr_count",   32'(wr_count), 32);
    check_output("t3_wr_bad",     32'(wr_bad), 0);

    // T4: run all nine tests; tests 3 and 7 expect a different PC
    stub_never = 1'b0; stub_n = 10; stub_pc = 5'h17;
    apply_stimulus(1'b1, 4'd5, 0);
    wait_done(1500);
    tick();
    check_output("t4_rv_count",   32'(rv_count), 9);
    check_output("t4_pass_count", 32'(pass_count), 7);
    check_output("t4_fail_count", 32'(fail_count), 2);
    check_output("t4_pass_mask",  32'(rv_pass_mask), 32'h177);
    check_output("t4_wr_count",   32'(wr_count), 288);
    check_output("t4_wr_bad",     32'(wr_bad), 0);
    check_output("t4_busy",       32'(busy), 0);
    for (int i = 0; i < NT; i++) check_output("t4_test_order", 32'(rv_tests[i]), 32'(i));

    // T5a: abort during LOAD after word 10 is written
    stub_n = 40;
    apply_stimulus(1'b0, 4'd0, 0);
    wait_write(5'd10, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("t5a_busy",      32'(busy), 0);
    check_output("t5a_mem_wr_en", 32'(mem_wr_en), 0);
    check_output("t5a_cpu_rst",   32'(cpu_rst_), 0);
    check_output("t5a_done",      32'(done), 0);
    for (int i = 0; i < 20; i++) tick();
    check_output("t5a_wr_count",  32'(wr_count), 11);
    check_output("t5a_rv_count",  32'(rv_count), 0);

    // T5b: abort during RUN of the second test of a run-all session
    apply_stimulus(1'b1, 4'd0, 0);
    wait_result(300, lat);
    tick();
    wait_cpu_run(200);
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("t5b_busy",       32'(busy), 0);
    check_output("t5b_cpu_rst",    32'(cpu_rst_), 0);
    check_output("t5b_mem_wr_en",  32'(mem_wr_en), 0);
    check_output("t5b_done",       32'(done), 0);
    check_output("t5b_pass_kept",  32'(pass_count), 1);
    for (int i = 0; i < 60; i++) tick();
    check_output("t5b_rv_count",   32'(rv_count), 1);

    // T5c: clean rerun after abort
    apply_stimulus(1'b0, 4'd0, 0);
    wait_result(300, lat);
    check_output("t5c_latency", 32'(lat), 80);
    check_output("t5c_pass",    32'(test_pass), 1);
    tick();
    check_output("t5c_pass_count", 32'(pass_count), 1);
    check_output("t5c_done",       32'(done), 1);
    check_output("t5c_wr_count",   32'(wr_count), 32);
    check_output("t5c_wr_bad",     32'(wr_bad), 0);

    // T6: halt during HOLD and start during RUN are ignored; halt on the
    // final allowed cycle is a pass, not a timeout
    stub_n = 100;
    apply_stimulus(1'b0, 4'd0, 0);
    wait_write(5'd31, 100);
    force_halt = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    force_halt = 1'b0;
    wait_cpu_run(50);
    for (int i = 0; i < 3; i++) tick();
    start = 1'b1; run_all = 1'b1; test_sel = 4'd5;
    tick();
    start = 1'b0; run_all = 1'b0;
    check_output("t6_busy",     32'(busy), 1);
    check_output("t6_cur_test", 32'(cur_test), 0);
    wait_result(300, lat);
    check_output("t6_pass",       32'(test_pass), 1);
    check_output("t6_timeout",    32'(test_timeout), 0);
    check_output("t6_run_cycles", 32'(run_cycles), 100);
    tick(); tick();
    check_output("t6_rv_count",   32'(rv_count), 1);
    check_output("t6_done",       32'(done), 1);
    check_output("t6_pass_count", 32'(pass_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
